fifo_uart_drain: RTL

//  Read-side consumer of the sniffer byte FIFO (fifo_generator_0, standard read mode, 1-cycle read latency).

---
 rtl/sniffer_pkg.sv | 9 +
 rtl/baud_tick_gen.sv | 24 ++
 rtl/fifo_uart_drain.sv | 82 ++++++++
 3 files changed

// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared types and constants for the sniffer UART drain path
//   drain_state_t : read-side drain FSM states
//   DATA_W        : FIFO / UART data width
//   UART_IDLE     : level of an idle UART line
package sniffer_pkg;
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} drain_state_t;
    localparam int DATA_W = 8;
    localparam logic UART_IDLE = 1'b1;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter, ticks on the last clk of each UART bit
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : hold the counter at zero (start a fresh bit period next cycle)
//   o_tick  : high on the last cycle of every CLKS_PER_BIT-cycle period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (i_clr || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
    assign o_tick = !i_clr && r_cnt == LAST;
endmodule

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from the capture FIFO and sends them as UART 8N1/8N2, LSB first
//   i_clk         : system clock
//   i_rst_n       : asynchronous active-low reset
//   i_enable      : 1 = drain the FIFO, 0 = finish the current frame then idle
//   i_fifo_empty  : FIFO empty flag
//   i_fifo_dout   : FIFO read data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en  : single-cycle FIFO pop strobe
//   o_tx          : UART line, idle high
//   o_busy        : high from POP until the last stop bit ends
//   o_frame_done  : pulse on the last cycle of the final stop bit
module fifo_uart_drain
    import sniffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_dout,
    output logic              o_fifo_rd_en,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_frame_done
);
    localparam logic [2:0] LAST_BIT  = 3'd7;
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    drain_state_t      r_state;
    logic [DATA_W-1:0] r_shift;
    logic [2:0]        r_bit_idx;
    logic              w_tick;
    logic              w_clr;
    logic              w_go;
    // Holding the counter clear through IDLE/POP/LOAD makes START begin a full bit period;
    // later state changes all happen on a tick, where the counter wraps to zero anyway.
    assign w_clr = r_state == IDLE || r_state == POP || r_state == LOAD;
    assign w_go  = i_enable && !i_fifo_empty;
    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE:  r_state <= w_go ? POP : IDLE;
                POP:   r_state <= LOAD;
                LOAD: begin
                    r_shift <= i_fifo_dout;
                    r_state <= START;
                end
                START: if (w_tick) begin
                    r_bit_idx <= '0;
                    r_state   <= DATA;
                end
                DATA: if (w_tick) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= (r_bit_idx == LAST_BIT) ? '0 : r_bit_idx + 1'b1;
                    r_state   <= (r_bit_idx == LAST_BIT) ? STOP : DATA;
                end
                // r_bit_idx is reused here to count stop bits.
                STOP: if (w_tick) begin
                    r_bit_idx <= (r_bit_idx == LAST_STOP) ? '0 : r_bit_idx + 1'b1;
                    r_state   <= (r_bit_idx != LAST_STOP) ? STOP : w_go ? POP : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    always_comb begin
        o_fifo_rd_en = r_state == POP;
        o_busy       = r_state != IDLE;
        o_tx         = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : UART_IDLE;
        o_frame_done = r_state == STOP && w_tick && r_bit_idx == LAST_STOP;
    end
endmodule
